ysyx_23060077_mem_arb: RTL and testbench
========================================

# ysyx_23060077_mem_arb

Two-requester arbiter sharing the single memory-bus master port between the instruction fetch unit (read-only) and the load/store unit (read and write). It sits between the IFU/LSU handshake interfaces and the AXI bridge, using the same valid/ready/last/size/len signalling on both sides. The grant is held for a whole transaction and released only on the final beat.

## Interface
Parameters:
- ADDR_WIDTH, 32, bus address width
- DATA_WIDTH, 32, bus data width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ifu_r_valid_i / ifu_r_addr_i / ifu_r_size_i / ifu_r_len_i  in  1 / ADDR_WIDTH / 3 / 8  IFU read request
- ifu_r_ready_o / ifu_r_data_o / ifu_r_last_o  out  1 / DATA_WIDTH / 1  IFU read response
- lsu_r_valid_i / lsu_r_addr_i / lsu_r_size_i / lsu_r_len_i  in  1 / ADDR_WIDTH / 3 / 8  LSU read request
- lsu_r_ready_o / lsu_r_data_o / lsu_r_last_o  out  1 / DATA_WIDTH / 1  LSU read response
- lsu_w_valid_i / lsu_w_addr_i / lsu_w_data_i / lsu_w_size_i / lsu_w_len_i  in  1 / ADDR_WIDTH / DATA_WIDTH / 3 / 8  LSU write request
- lsu_w_ready_o / lsu_w_last_o  out  1 / 1  LSU write response
- bus_r_valid_o / bus_r_addr_o / bus_r_size_o / bus_r_len_o  out  1 / ADDR_WIDTH / 3 / 8  shared read request
- bus_r_ready_i / bus_r_data_i / bus_r_last_i  in  1 / DATA_WIDTH / 1  shared read response
- bus_w_valid_o / bus_w_addr_o / bus_w_data_o / bus_w_size_o / bus_w_len_o  out  1 / ADDR_WIDTH / DATA_WIDTH / 3 / 8  shared write request
- bus_w_ready_i / bus_w_last_i  in  1 / 1  shared write response
- arb_busy_o  out  1  high in any granted state

## Operation
- FSM states: IDLE, IFU_RD, LSU_RD, LSU_WR; registered, reset to IDLE.
- IDLE: sample requests; LSU write > LSU read (LSU never raises both; write wins if it does); LSU vs IFU priority per Configuration. No request -> stay IDLE.
- Granted state: bus request fields driven combinationally from the owner's inputs; bus_*_valid_o = owner valid. Non-owner request fields on bus = 0.
- Response routing: owner's ready/last/data = bus inputs (same cycle, combinational); all non-owner response outputs forced to 0.
- Release: bus_x_ready_i & bus_x_last_i in granted state -> IDLE next cycle. Multi-beat (len>0): intermediate beats forwarded, grant held.
- Abort: owner valid low in a granted state with no last that cycle -> IDLE next cycle (supports IFU flush).
- Requests arriving while granted to the other requester wait; no queueing beyond the held valid.

## Timing
- Reset (asserted or mid-transaction): state IDLE immediately; all valid/ready/last outputs 0, data/addr outputs 0, arb_busy_o 0; RR pointer favours LSU.
- Grant latency: request first seen in IDLE at cycle N -> state granted at N+1, bus valid high at N+1.
- Completion: last beat at cycle M -> owner sees ready&last at M; IDLE at M+1; next grant at M+2 earliest. Minimum one dead cycle between transactions.
- Zero-wait bus (ready&last in grant cycle): single-beat transaction occupies exactly 2 cycles (grant + IDLE).
- Simultaneous IFU and LSU requests in IDLE: resolved in one cycle; loser's valid must stay high until granted.

## Configuration
- YSYX_23060077_ARB_RR_EN defined: round-robin between IFU and LSU; 1-bit pointer flips to the other requester after each completed (not aborted) grant; on conflict the pointer side wins.
- Undefined: fixed priority, LSU always beats IFU; pointer logic absent.

## Test plan
- Single IFU read, addr 0x8000_0000, size 2, bus returns 0xDEAD_BEEF with last 3 cycles after grant -> ifu_r_ready_o/last_o/data_o=0xDEAD_BEEF that cycle, lsu outputs 0, IDLE next cycle.
- IFU and LSU read both valid in IDLE, fixed priority -> LSU granted first (bus addr = LSU addr), IFU granted at completion+2; with RR_EN and pointer at IFU -> IFU first.
- LSU write addr 0x1000_0004 data 0x1234_5678 size 2 -> bus_w fields match, lsu_w_last_o pulses with bus_w_last_i, IFU request held pending meanwhile.
- Burst IFU read len=3 -> four beats forwarded, grant held until fourth (last) beat, LSU request waits.
- IFU valid drops mid-transaction with no last -> IDLE next cycle, pending LSU granted the cycle after.
- Reset asserted during LSU_RD -> all outputs 0 asynchronously, state IDLE; after release a new IFU request is granted normally.

Source files
------------

// File: rtl/ysyx_23060077_mem_arb.sv
// Two-requester memory-bus arbiter (IFU read, LSU read/write) that holds the grant until the last beat.
// Define YSYX_23060077_ARB_RR_EN for IFU/LSU round-robin; otherwise LSU has fixed priority over IFU.
module ysyx_23060077_mem_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  ifu_r_valid_i,
  input  logic [ADDR_WIDTH-1:0] ifu_r_addr_i,
  input  logic [2:0]            ifu_r_size_i,
  input  logic [7:0]            ifu_r_len_i,
  output logic                  ifu_r_ready_o,
  output logic [DATA_WIDTH-1:0] ifu_r_data_o,
  output logic                  ifu_r_last_o,

  input  logic                  lsu_r_valid_i,
  input  logic [ADDR_WIDTH-1:0] lsu_r_addr_i,
  input  logic [2:0]            lsu_r_size_i,
  input  logic [7:0]            lsu_r_len_i,
  output logic                  lsu_r_ready_o,
  output logic [DATA_WIDTH-1:0] lsu_r_data_o,
  output logic                  lsu_r_last_o,

  input  logic                  lsu_w_valid_i,
  input  logic [ADDR_WIDTH-1:0] lsu_w_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_w_data_i,
  input  logic [2:0]            lsu_w_size_i,
  input  logic [7:0]            lsu_w_len_i,
  output logic                  lsu_w_ready_o,
  output logic                  lsu_w_last_o,

  output logic                  bus_r_valid_o,
  output logic [ADDR_WIDTH-1:0] bus_r_addr_o,
  output logic [2:0]            bus_r_size_o,
  output logic [7:0]            bus_r_len_o,
  input  logic                  bus_r_ready_i,
  input  logic [DATA_WIDTH-1:0] bus_r_data_i,
  input  logic                  bus_r_last_i,

  output logic                  bus_w_valid_o,
  output logic [ADDR_WIDTH-1:0] bus_w_addr_o,
  output logic [DATA_WIDTH-1:0] bus_w_data_o,
  output logic [2:0]            bus_w_size_o,
  output logic [7:0]            bus_w_len_o,
  input  logic                  bus_w_ready_i,
  input  logic                  bus_w_last_i,

  output logic                  arb_busy_o
);

  typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_t;

  state_t state, state_nxt;
  logic   lsu_req, lsu_first, r_done, w_done;

  assign lsu_req = lsu_w_valid_i | lsu_r_valid_i;
  assign r_done  = bus_r_ready_i & bus_r_last_i;
  assign w_done  = bus_w_ready_i & bus_w_last_i;

`ifdef YSYX_23060077_ARB_RR_EN
  // rr_ptr = 1 favours IFU; only completed transactions move it, aborts do not.
  logic rr_ptr;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                                rr_ptr <= 1'b0;
    else if (state == IFU_RD && r_done)                        rr_ptr <= 1'b0;
    else if ((state == LSU_RD && r_done) || (state == LSU_WR && w_done)) rr_ptr <= 1'b1;
  end
  assign lsu_first = ~rr_ptr;
`else
  assign lsu_first = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // A granted state exits on the last beat or when the owner withdraws its valid.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (lsu_req && (lsu_first || !ifu_r_valid_i))
          state_nxt = lsu_w_valid_i ? LSU_WR : LSU_RD;
        else if (ifu_r_valid_i)
          state_nxt = IFU_RD;
      end
      IFU_RD:  if (r_done || !ifu_r_valid_i) state_nxt = IDLE;
      LSU_RD:  if (r_done || !lsu_r_valid_i) state_nxt = IDLE;
      LSU_WR:  if (w_done || !lsu_w_valid_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus_r_valid_o = 1'b0;
    bus_r_addr_o  = '0;
    bus_r_size_o  = '0;
    bus_r_len_o   = '0;
    bus_w_valid_o = 1'b0;
    bus_w_addr_o  = '0;
    bus_w_data_o  = '0;
    bus_w_size_o  = '0;
    bus_w_len_o   = '0;
    ifu_r_ready_o = 1'b0;
    ifu_r_data_o  = '0;
    ifu_r_last_o  = 1'b0;
    lsu_r_ready_o = 1'b0;
    lsu_r_data_o  = '0;
    lsu_r_last_o  = 1'b0;
    lsu_w_ready_o = 1'b0;
    lsu_w_last_o  = 1'b0;
    case (state)
      IFU_RD: begin
        bus_r_valid_o = ifu_r_valid_i;
        bus_r_addr_o  = ifu_r_addr_i;
        bus_r_size_o  = ifu_r_size_i;
        bus_r_len_o   = ifu_r_len_i;
        ifu_r_ready_o = bus_r_ready_i;
        ifu_r_data_o  = bus_r_data_i;
        ifu_r_last_o  = bus_r_last_i;
      end
      LSU_RD: begin
        bus_r_valid_o = lsu_r_valid_i;
        bus_r_addr_o  = lsu_r_addr_i;
        bus_r_size_o  = lsu_r_size_i;
        bus_r_len_o   = lsu_r_len_i;
        lsu_r_ready_o = bus_r_ready_i;
        lsu_r_data_o  = bus_r_data_i;
        lsu_r_last_o  = bus_r_last_i;
      end
      LSU_WR: begin
        bus_w_valid_o = lsu_w_valid_i;
        bus_w_addr_o  = lsu_w_addr_i;
        bus_w_data_o  = lsu_w_data_i;
        bus_w_size_o  = lsu_w_size_i;
        bus_w_len_o   = lsu_w_len_i;
        lsu_w_ready_o = bus_w_ready_i;
        lsu_w_last_o  = bus_w_last_i;
      end
      default: ;
    endcase
  end

  assign arb_busy_o = (state != IDLE);

endmodule

// File: tb/tb_ysyx_23060077_mem_arb.sv
// Directed bench for ysyx_23060077_mem_arb: grant/data scoreboards checked with immediate assertions.
module tb_ysyx_23060077_mem_arb;
  logic        clock = 1'b0, reset = 1'b0;
  logic        ifu_r_valid_i = 0, lsu_r_valid_i = 0, lsu_w_valid_i = 0;
  logic [31:0] ifu_r_addr_i = 0, lsu_r_addr_i = 0, lsu_w_addr_i = 0, lsu_w_data_i = 0;
  logic [2:0]  ifu_r_size_i = 0, lsu_r_size_i = 0, lsu_w_size_i = 0;
  logic [7:0]  ifu_r_len_i = 0, lsu_r_len_i = 0, lsu_w_len_i = 0;
  logic        ifu_r_ready_o, ifu_r_last_o, lsu_r_ready_o, lsu_r_last_o, lsu_w_ready_o, lsu_w_last_o;
  logic [31:0] ifu_r_data_o, lsu_r_data_o;
  logic        bus_r_valid_o, bus_w_valid_o, arb_busy_o;
  logic [31:0] bus_r_addr_o, bus_w_addr_o, bus_w_data_o;
  logic [2:0]  bus_r_size_o, bus_w_size_o;
  logic [7:0]  bus_r_len_o, bus_w_len_o;
  logic        bus_r_ready_i = 0, bus_r_last_i = 0, bus_w_ready_i = 0, bus_w_last_i = 0;
  logic [31:0] bus_r_data_i = 0;

  ysyx_23060077_mem_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .ifu_r_valid_i(ifu_r_valid_i), .ifu_r_addr_i(ifu_r_addr_i), .ifu_r_size_i(ifu_r_size_i),
    .ifu_r_len_i(ifu_r_len_i), .ifu_r_ready_o(ifu_r_ready_o), .ifu_r_data_o(ifu_r_data_o),
    .ifu_r_last_o(ifu_r_last_o),
    .lsu_r_valid_i(lsu_r_valid_i), .lsu_r_addr_i(lsu_r_addr_i), .lsu_r_size_i(lsu_r_size_i),
    .lsu_r_len_i(lsu_r_len_i), .lsu_r_ready_o(lsu_r_ready_o), .lsu_r_data_o(lsu_r_data_o),
    .lsu_r_last_o(lsu_r_last_o),
    .lsu_w_valid_i(lsu_w_valid_i), .lsu_w_addr_i(lsu_w_addr_i), .lsu_w_data_i(lsu_w_data_i),
    .lsu_w_size_i(lsu_w_size_i), .lsu_w_len_i(lsu_w_len_i), .lsu_w_ready_o(lsu_w_ready_o),
    .lsu_w_last_o(lsu_w_last_o),
    .bus_r_valid_o(bus_r_valid_o), .bus_r_addr_o(bus_r_addr_o), .bus_r_size_o(bus_r_size_o),
    .bus_r_len_o(bus_r_len_o), .bus_r_ready_i(bus_r_ready_i), .bus_r_data_i(bus_r_data_i),
    .bus_r_last_i(bus_r_last_i),
    .bus_w_valid_o(bus_w_valid_o), .bus_w_addr_o(bus_w_addr_o), .bus_w_data_o(bus_w_data_o),
    .bus_w_size_o(bus_w_size_o), .bus_w_len_o(bus_w_len_o), .bus_w_ready_i(bus_w_ready_i),
    .bus_w_last_i(bus_w_last_i),
    .arb_busy_o(arb_busy_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  size;
    logic [7:0]  len;
  } grant_t;

  grant_t      gq[$];
  logic [31:0] dq[$];
  int          total = 0, passed = 0;
  bit          favour_ifu = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic grant_t mk(bit wr, logic [31:0] a, logic [31:0] d, logic [2:0] s, logic [7:0] l);
    grant_t g;
    g.wr = wr; g.addr = a; g.data = d; g.size = s; g.len = l;
    return g;
  endfunction

  function automatic bit lsu_wins();
`ifdef YSYX_23060077_ARB_RR_EN
    return !favour_ifu;
`else
    return 1'b1;
`endif
  endfunction

  task automatic note_done(input bit was_ifu);
`ifdef YSYX_23060077_ARB_RR_EN
    favour_ifu = !was_ifu;
`endif
  endtask

  task automatic next_cycle();
    @(negedge clock);
    bus_r_ready_i = 0; bus_r_last_i = 0; bus_r_data_i = 0;
    bus_w_ready_i = 0; bus_w_last_i = 0;
    #1;
  endtask

  task automatic drop(input int own);
    case (own)
      0:       ifu_r_valid_i = 0;
      1:       lsu_r_valid_i = 0;
      default: lsu_w_valid_i = 0;
    endcase
  endtask

  // Waits (bounded) for the next bus request and compares it with the scoreboard head.
  task automatic wait_grant(input int exp_n);
    grant_t g;
    int n = 0;
    do begin @(negedge clock); #1; n++; end
    while (!(bus_r_valid_o || bus_w_valid_o) && n < 20);
    chk("grant_latency", n, exp_n);
    g = (gq.size() != 0) ? gq.pop_front() : mk(0, 32'hFFFF_FFFF, 0, 0, 0);
    chk("grant_busy", arb_busy_o, 1);
    chk("grant_is_write", bus_w_valid_o, g.wr);
    if (g.wr) begin
      chk("bus_w_addr", bus_w_addr_o, g.addr);
      chk("bus_w_data", bus_w_data_o, g.data);
      chk("bus_w_size", bus_w_size_o, g.size);
      chk("bus_w_len", bus_w_len_o, g.len);
      chk("bus_r_quiet", {bus_r_valid_o, bus_r_addr_o}, 0);
    end else begin
      chk("bus_r_addr", bus_r_addr_o, g.addr);
      chk("bus_r_size", bus_r_size_o, g.size);
      chk("bus_r_len", bus_r_len_o, g.len);
      chk("bus_w_quiet", {bus_w_valid_o, bus_w_addr_o}, 0);
    end
  endtask

  // Drives one response beat in the current cycle and checks its routing.
  task automatic beat(input int own, input logic [31:0] d, input bit last);
    logic [31:0] e;
    if (own == 2) begin
      bus_w_ready_i = 1; bus_w_last_i = last;
    end else begin
      bus_r_ready_i = 1; bus_r_last_i = last; bus_r_data_i = d;
      dq.push_back(d);
    end
    #1;
    case (own)
      0: begin
        e = dq.pop_front();
        chk("ifu_ready", ifu_r_ready_o, 1);
        chk("ifu_last", ifu_r_last_o, last);
        chk("ifu_data", ifu_r_data_o, e);
        chk("lsu_r_masked", {lsu_r_ready_o, lsu_r_last_o, lsu_r_data_o}, 0);
        chk("lsu_w_masked", {lsu_w_ready_o, lsu_w_last_o}, 0);
      end
      1: begin
        e = dq.pop_front();
        chk("lsu_r_ready", lsu_r_ready_o, 1);
        chk("lsu_r_last", lsu_r_last_o, last);
        chk("lsu_r_data", lsu_r_data_o, e);
        chk("ifu_masked", {ifu_r_ready_o, ifu_r_last_o, ifu_r_data_o}, 0);
      end
      default: begin
        chk("lsu_w_ready", lsu_w_ready_o, 1);
        chk("lsu_w_last", lsu_w_last_o, last);
        chk("ifu_masked_wr", {ifu_r_ready_o, lsu_r_ready_o}, 0);
      end
    endcase
  endtask

  task automatic conflict_reads(input logic [31:0] ia, input logic [31:0] la);
    bit lw;
    int o1, o2;
    @(negedge clock);
    ifu_r_valid_i = 1; ifu_r_addr_i = ia; ifu_r_size_i = 2; ifu_r_len_i = 0;
    lsu_r_valid_i = 1; lsu_r_addr_i = la; lsu_r_size_i = 2; lsu_r_len_i = 0;
    lw = lsu_wins();
    o1 = lw ? 1 : 0;
    o2 = lw ? 0 : 1;
    gq.push_back(mk(0, lw ? la : ia, 0, 2, 0));
    gq.push_back(mk(0, lw ? ia : la, 0, 2, 0));
    #1;
    chk("conflict_idle", bus_r_valid_o, 0);
    wait_grant(1);
    beat(o1, 32'hA5A5_0001, 1);
    next_cycle(); drop(o1);
    chk("conflict_dead_cycle", arb_busy_o, 0);
    note_done(o1 == 0);
    wait_grant(1);
    beat(o2, 32'hA5A5_0002, 1);
    next_cycle(); drop(o2);
    note_done(o2 == 0);
  endtask

  initial begin
    // Reset holds everything quiet even with requests and bus responses present.
    ifu_r_valid_i = 1; ifu_r_addr_i = 32'h8000_0000;
    bus_r_ready_i = 1; bus_r_last_i = 1; bus_r_data_i = 32'hFFFF_FFFF;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_busy", arb_busy_o, 0);
    chk("rst_bus_r", {bus_r_valid_o, bus_r_addr_o}, 0);
    chk("rst_ifu_resp", {ifu_r_ready_o, ifu_r_last_o, ifu_r_data_o}, 0);
    @(negedge clock);
    ifu_r_valid_i = 0; ifu_r_addr_i = 0;
    bus_r_ready_i = 0; bus_r_last_i = 0; bus_r_data_i = 0;
    reset = 1;

    // Single IFU read, response three cycles after grant.
    @(negedge clock);
    ifu_r_valid_i = 1; ifu_r_addr_i = 32'h8000_0000; ifu_r_size_i = 2; ifu_r_len_i = 0;
    gq.push_back(mk(0, 32'h8000_0000, 0, 2, 0));
    #1;
    chk("t1_not_yet", bus_r_valid_o, 0);
    wait_grant(1);
    next_cycle(); chk("t1_wait1", ifu_r_ready_o, 0);
    next_cycle(); chk("t1_wait2", ifu_r_ready_o, 0);
    next_cycle(); beat(0, 32'hDEAD_BEEF, 1);
    next_cycle(); drop(0);
    chk("t1_idle", arb_busy_o, 0);
    note_done(1);

    // Simultaneous IFU/LSU reads.
    conflict_reads(32'h8000_0100, 32'h2000_0010);

    // LSU write with IFU pending.
    @(negedge clock);
    begin
      bit lw;
      int o1, o2;
      lsu_w_valid_i = 1; lsu_w_addr_i = 32'h1000_0004; lsu_w_data_i = 32'h1234_5678;
      lsu_w_size_i = 2; lsu_w_len_i = 0;
      ifu_r_valid_i = 1; ifu_r_addr_i = 32'h8000_0200; ifu_r_size_i = 2; ifu_r_len_i = 0;
      lw = lsu_wins();
      o1 = lw ? 2 : 0;
      o2 = lw ? 0 : 2;
      if (lw) begin
        gq.push_back(mk(1, 32'h1000_0004, 32'h1234_5678, 2, 0));
        gq.push_back(mk(0, 32'h8000_0200, 0, 2, 0));
      end else begin
        gq.push_back(mk(0, 32'h8000_0200, 0, 2, 0));
        gq.push_back(mk(1, 32'h1000_0004, 32'h1234_5678, 2, 0));
      end
      #1;
      wait_grant(1);
      if (o1 == 2) begin
        next_cycle();
        bus_r_ready_i = 1; bus_r_last_i = 1;
        #1;
        chk("t3_w_last_low", lsu_w_last_o, 0);
        chk("t3_ifu_blocked", {ifu_r_ready_o, ifu_r_last_o, bus_r_valid_o}, 0);
      end
      next_cycle(); beat(o1, 32'hC0DE_0003, 1);
      next_cycle(); drop(o1); note_done(o1 == 0);
      wait_grant(1);
      beat(o2, 32'hC0DE_0004, 1);
      next_cycle(); drop(o2); note_done(o2 == 0);
    end

    // Four-beat IFU burst while an LSU read waits.
    @(negedge clock);
    ifu_r_valid_i = 1; ifu_r_addr_i = 32'h8000_1000; ifu_r_size_i = 2; ifu_r_len_i = 3;
    gq.push_back(mk(0, 32'h8000_1000, 0, 2, 3));
    #1;
    wait_grant(1);
    lsu_r_valid_i = 1; lsu_r_addr_i = 32'h2000_0020; lsu_r_size_i = 2; lsu_r_len_i = 0;
    gq.push_back(mk(0, 32'h2000_0020, 0, 2, 0));
    beat(0, 32'h1111_0000, 0);
    for (int i = 1; i < 4; i++) begin
      next_cycle();
      chk("t4_grant_held", bus_r_addr_o, 32'h8000_1000);
      beat(0, 32'h1111_0000 + i, i == 3);
    end
    next_cycle(); drop(0);
    chk("t4_idle", arb_busy_o, 0);
    note_done(1);
    wait_grant(1);
    beat(1, 32'h2222_0001, 1);
    next_cycle(); drop(1); note_done(0);

    // IFU flush: valid drops with no last; pending LSU follows.
    @(negedge clock);
    ifu_r_valid_i = 1; ifu_r_addr_i = 32'h8000_2000; ifu_r_size_i = 2; ifu_r_len_i = 1;
    gq.push_back(mk(0, 32'h8000_2000, 0, 2, 1));
    #1;
    wait_grant(1);
    lsu_r_valid_i = 1; lsu_r_addr_i = 32'h2000_0030; lsu_r_size_i = 2; lsu_r_len_i = 0;
    gq.push_back(mk(0, 32'h2000_0030, 0, 2, 0));
    next_cycle(); drop(0);
    #1;
    chk("t5_abort_valid", bus_r_valid_o, 0);
    next_cycle();
    chk("t5_idle", arb_busy_o, 0);
    wait_grant(1);
    beat(1, 32'h3333_0001, 1);
    next_cycle(); drop(1); note_done(0);

    // Second conflict: round-robin now favours IFU; fixed priority still LSU.
    conflict_reads(32'h8000_0300, 32'h2000_0050);

    // Reset in the middle of an LSU read burst.
    @(negedge clock);
    lsu_r_valid_i = 1; lsu_r_addr_i = 32'h2000_0040; lsu_r_size_i = 2; lsu_r_len_i = 2;
    gq.push_back(mk(0, 32'h2000_0040, 0, 2, 2));
    #1;
    wait_grant(1);
    bus_r_ready_i = 1; bus_r_last_i = 0; bus_r_data_i = 32'h4444_0001;
    reset = 0;
    #1;
    chk("t7_rst_busy", arb_busy_o, 0);
    chk("t7_rst_bus_r", {bus_r_valid_o, bus_r_addr_o, bus_r_len_o}, 0);
    chk("t7_rst_lsu_resp", {lsu_r_ready_o, lsu_r_last_o, lsu_r_data_o}, 0);
    favour_ifu = 1'b0;
    next_cycle(); drop(1);
    reset = 1;
    @(negedge clock);
    ifu_r_valid_i = 1; ifu_r_addr_i = 32'h8000_3000; ifu_r_size_i = 2; ifu_r_len_i = 0;
    gq.push_back(mk(0, 32'h8000_3000, 0, 2, 0));
    #1;
    wait_grant(1);
    beat(0, 32'h5555_0001, 1);
    next_cycle(); drop(0); note_done(1);
    chk("final_idle", arb_busy_o, 0);
    chk("scoreboard_empty", gq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
